fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013, meaning the instruction word presented while if_valid=0.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have port stall, input, 1, downstream (decode) not accepting this cycle.
REQ-006 SHALL have port redirect_en, input, 1, branch/jump redirect and flush request.
REQ-007 SHALL have port redirect_pc, input, 32, redirect target.
REQ-008 SHALL have port imem_req, output, 1, read request to instruction memory.
REQ-009 SHALL have port imem_addr, output, 32, word-aligned read address.
REQ-010 SHALL have port imem_rdata, input, 32, read data, valid exactly one cycle after an accepted imem_req.
REQ-011 SHALL have port if_valid, output, 1, if_inst/if_pc hold a live instruction.
REQ-012 SHALL have port if_inst, output, 32, instruction to the decoder.
REQ-013 SHALL have port if_pc, output, 32, address of if_inst.

Function
REQ-014 SHALL keep fetch PC register fpc; imem_addr = fpc; fpc += 4 on each issued request, wrapping 32'hFFFF_FFFC -> 0.
REQ-015 SHALL track one outstanding request (flag plus its PC); the response is captured into the instruction buffer in the cycle imem_rdata is valid.
REQ-016 SHALL use an instruction buffer of DEPTH entries (see Configuration); if_valid = (count != 0), if_inst/if_pc = head entry.
REQ-017 SHALL pop the head when if_valid=1 and stall=0; push and pop in the same cycle leave count unchanged.
REQ-018 SHALL assert imem_req only when count + outstanding - pop < DEPTH and redirect_en=0; the buffer never overflows.
REQ-019 SHALL drive if_inst = NOP_INST and if_pc = 0 whenever if_valid=0.
REQ-020 SHALL, on redirect_en=1, clear the buffer, mark any outstanding response for discard, hold imem_req=0, and load fpc = {redirect_pc[31:2], 2'b00}; the first request at the new target is issued the next cycle.
REQ-021 SHALL give redirect_en priority over stall, and over any push or pop in the same cycle.
REQ-022 SHALL drop a discarded response without changing count or if_valid.
REQ-023 SHALL hold if_inst/if_pc stable while stall=1 and if_valid=1.
REQ-024 SHALL give minimum latency of 2 cycles from request issue to if_valid (issue cycle, response cycle, valid on the following edge).

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge: fpc=RESET_PC, count=0, outstanding=0, imem_req=0, if_valid=0, if_inst=NOP_INST, if_pc=0.
REQ-026 SHALL discard any response belonging to a request issued before reset asserted.
REQ-027 SHALL issue the first request at RESET_PC in the first cycle with rst_n=1.

Configuration
REQ-028 SHALL compile a 2-entry FIFO buffer (DEPTH=2, sustained 1 instruction/cycle) when macro FETCH_BUF_EN is defined.
REQ-029 SHALL compile a 1-entry holding register (DEPTH=1, sustained 1 instruction per 2 cycles) when FETCH_BUF_EN is undefined; all other requirements are unchanged.

Verification
REQ-030 SHALL cover: reset release with RESET_PC=0, memory returning addr+0x100, no stall -> imem_addr 0,4,8...; if_valid from cycle 2; if_pc 0,4,8 consecutive (FETCH_BUF_EN).
REQ-031 SHALL cover: stall=1 for 3 cycles with if_pc=0x8 -> if_pc/if_inst frozen; imem_req drops once buffer full; no lost or duplicated PC after release.
REQ-032 SHALL cover: redirect_en=1, redirect_pc=0x203 with a request outstanding -> next cycle imem_addr=0x200; stale response dropped; next if_pc=0x200.
REQ-033 SHALL cover: redirect_en and stall together with if_valid=1 -> buffer cleared, if_valid=0 next cycle, if_inst=0x00000013.
REQ-034 SHALL cover: fpc=0xFFFFFFFC -> next imem_addr=0x00000000.
REQ-035 SHALL cover: FETCH_BUF_EN undefined, no stall -> imem_req every other cycle; if_pc 0,4,8 with a one-cycle if_valid gap between instructions.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: fetch PC, one outstanding imem request, small instruction buffer.
// Define FETCH_BUF_EN for a 2-entry buffer (1 instr/cycle); otherwise a 1-entry holding register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc
);

`ifdef FETCH_BUF_EN
   localparam int unsigned DEPTH = 2;
`else
   localparam int unsigned DEPTH = 1;
`endif

   logic [31:0] fpc;
   logic [31:0] out_pc;
   logic        outstanding;
   logic [1:0]  count;
   logic        rd_ptr;
   logic        wr_ptr;
   logic [31:0] buf_inst [2];
   logic [31:0] buf_pc   [2];
   logic        push;
   logic        pop;
   logic [2:0]  occupancy;
   logic [2:0]  limit;
   logic        unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   function automatic logic ptr_next(input logic p);
      return (DEPTH == 1) ? 1'b0 : ~p;
   endfunction

   // Request only if the reply is guaranteed a free slot, counting this cycle's pop.
   always_comb begin
      pop       = (count != '0) && !stall && !redirect_en;
      push      = outstanding && !redirect_en;
      occupancy = {1'b0, count} + {2'b00, outstanding};
      limit     = 3'(DEPTH) + {2'b00, pop};
      imem_req  = rst_n && !redirect_en && (occupancy < limit);
   end

   assign imem_addr = fpc;
   assign if_valid  = (count != '0);
   assign if_inst   = if_valid ? buf_inst[rd_ptr] : NOP_INST;
   assign if_pc     = if_valid ? buf_pc[rd_ptr]   : '0;

   // Clearing outstanding on reset/redirect discards the in-flight reply: it lands
   // in that very cycle, which is never a push cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fpc         <= RESET_PC;
         outstanding <= 1'b0;
         out_pc      <= '0;
         count       <= '0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
      end else if (redirect_en) begin
         fpc         <= {redirect_pc[31:2], 2'b00};
         outstanding <= 1'b0;
         count       <= '0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
      end else begin
         outstanding <= imem_req;
         if (imem_req) begin
            fpc    <= fpc + 32'd4;
            out_pc <= fpc;
         end
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         buf_inst[wr_ptr] <= imem_rdata;
         buf_pc[wr_ptr]   <= out_pc;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory replies addr+0x100, scoreboard queue of expected PCs.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_q [$];
   logic found;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_en(redirect_en),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc)
   );

   // One-cycle-latency instruction memory.
   always @(posedge clk) imem_rdata <= imem_req ? imem_addr + 32'h100 : 32'hDEAD_BEEF;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_from(input logic [31:0] start);
      exp_q.delete();
      for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
   endtask

   task automatic sb_check();
      logic [31:0] e;
      if (rst_n === 1'b1 && if_valid === 1'b1 && stall === 1'b0 && redirect_en === 1'b0) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL sb_empty: observed pc %h expected none", if_pc);
         end else begin
            e = exp_q.pop_front();
            check("sb_pc", if_pc, e);
            check("sb_inst", if_inst, e + 32'h100);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      sb_check();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
      repeat (3) tick();
      check("rst_valid", if_valid, 0);
      check("rst_inst", if_inst, 32'h13);
      check("rst_pc", if_pc, 0);
      check("rst_req", imem_req, 0);

      rst_n = 1'b1;
      expect_from(32'h0);
      #1;
      check("c0_req", imem_req, 1);
      check("c0_addr", imem_addr, 0);
      check("c0_valid", if_valid, 0);
      tick();
      check("c1_addr", imem_addr, 4);
      check("c1_valid", if_valid, 0);
      tick();
      check("c2_valid", if_valid, 1);
      check("c2_pc", if_pc, 0);
      check("c2_inst", if_inst, 32'h100);
`ifdef FETCH_BUF_EN
      check("c2_addr", imem_addr, 8);
      tick();
      check("c3_valid", if_valid, 1);
      check("c3_pc", if_pc, 4);
      check("c3_req", imem_req, 1);
      tick();
      check("c4_pc", if_pc, 8);
`else
      check("c2_req", imem_req, 1);
      check("c2_addr", imem_addr, 4);
      tick();
      check("c3_valid", if_valid, 0);
      check("c3_req", imem_req, 0);
      check("c3_inst", if_inst, 32'h13);
      tick();
      check("c4_valid", if_valid, 1);
      check("c4_pc", if_pc, 4);
      check("c4_req", imem_req, 1);
`endif

      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (if_valid === 1'b1 && if_pc === 32'h8) begin found = 1'b1; break; end
         tick();
      end
      check("wait_pc8", found, 1);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("st_valid", if_valid, 1);
         check("st_pc", if_pc, 8);
         check("st_inst", if_inst, 32'h108);
      end
      check("st_req", imem_req, 0);
      stall = 1'b0;
      repeat (8) tick();

      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (imem_req === 1'b1) begin found = 1'b1; break; end
         tick();
      end
      check("wait_req", found, 1);
      tick();
      redirect_en = 1'b1; redirect_pc = 32'h203;
      #1;
      check("rd_req_hold", imem_req, 0);
      tick();
      redirect_en = 1'b0;
      expect_from(32'h200);
      #1;
      check("rd_addr", imem_addr, 32'h200);
      check("rd_req", imem_req, 1);
      check("rd_valid", if_valid, 0);
      tick();
      check("rd1_valid", if_valid, 0);
      tick();
      check("rd2_valid", if_valid, 1);
      check("rd2_pc", if_pc, 32'h200);
      repeat (4) tick();

      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (if_valid === 1'b1) begin found = 1'b1; break; end
         tick();
      end
      check("wait_valid", found, 1);
      stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h400;
      tick();
      stall = 1'b0; redirect_en = 1'b0;
      expect_from(32'h400);
      #1;
      check("rs_valid", if_valid, 0);
      check("rs_inst", if_inst, 32'h13);
      check("rs_pc", if_pc, 0);
      repeat (6) tick();

      redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_en = 1'b0;
      expect_from(32'hFFFF_FFFC);
      #1;
      check("wr_addr", imem_addr, 32'hFFFF_FFFC);
      tick();
      check("wr_addr_wrap", imem_addr, 32'h0);
      repeat (8) tick();

      rst_n = 1'b0;
      tick();
      check("rs2_valid", if_valid, 0);
      check("rs2_req", imem_req, 0);
      rst_n = 1'b1;
      expect_from(32'h0);
      #1;
      check("rs2_addr", imem_addr, 0);
      tick();
      check("rs2_c1_valid", if_valid, 0);
      tick();
      check("rs2_c2_pc", if_pc, 0);
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
